// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to BCD via double-dabble, scanned 7-segment display, session high score
module score_display #(
    parameter int SCORE_W  = 14,
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 0
) (
    input  logic               clk3,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               game_over,
    output logic [6:0]         seg,
    output logic [NDIG-1:0]    an,
    output logic [SCORE_W-1:0] hi_score,
    output logic               busy
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(SCORE_W + 1);
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [31:0] MAXV = 32'(10 ** NDIG - 1);
    localparam logic [SCORE_W-1:0] MAXV_S = MAXV[SCORE_W-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SCORE_W-1:0] last;
    logic [SCORE_W-1:0] bin;
    logic [BW-1:0]      bcd;
    logic [BW-1:0]      disp;
    logic [CW-1:0]      bitcnt;
    logic [DW-1:0]      digit;
    logic [PW-1:0]      presc;
    logic               go_d;

    logic [BW-1:0]      bcd_adj;
    logic [BW-1:0]      bcd_sh;
    logic [SCORE_W-1:0] bin_sh;
    logic [SCORE_W-1:0] score_clamped;
    logic               score_changed;
    logic [3:0]         nib;
    logic [BW-1:0]      upper;
    logic [6:0]         seg_pat;
    logic [NDIG-1:0]    an_pat;

    assign score_changed = (score != last);
    // Scores beyond the displayable range convert as all nines; last keeps the raw value.
    assign score_clamped = (32'(score) > MAXV) ? MAXV_S : score;
    assign busy          = (state != IDLE);

    // Add-3 correction of every nibble >= 5, then one left shift of {bcd, bin}.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcd_sh, bin_sh} = {bcd_adj, bin} << 1;
    end

    // Conversion FSM next-state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (score_changed) state_next = SHIFT;
            SHIFT:   if (bitcnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion FSM state register.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Conversion datapath: latch score, shift, publish the finished BCD to disp.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            last   <= '0;
            bin    <= '0;
            bcd    <= '0;
            bitcnt <= '0;
            disp   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (score_changed) begin
                        last   <= score;
                        bin    <= score_clamped;
                        bcd    <= '0;
                        bitcnt <= CW'(SCORE_W);
                    end
                end
                SHIFT: begin
                    bcd    <= bcd_sh;
                    bin    <= bin_sh;
                    bitcnt <= bitcnt - CW'(1);
                end
                DONE: disp <= bcd;
                default: ;
            endcase
        end
    end

    // Segment pattern of the current digit, blanking leading zeros above digit 0.
    always_comb begin
        nib   = disp[4*int'(digit) +: 4];
        upper = disp >> (4 * int'(digit));
        an_pat = ~(NDIG'(1) << digit);
        case (nib)
            4'd0:    seg_pat = 7'h40;
            4'd1:    seg_pat = 7'h79;
            4'd2:    seg_pat = 7'h24;
            4'd3:    seg_pat = 7'h30;
            4'd4:    seg_pat = 7'h19;
            4'd5:    seg_pat = 7'h12;
            4'd6:    seg_pat = 7'h02;
            4'd7:    seg_pat = 7'h78;
            4'd8:    seg_pat = 7'h00;
            4'd9:    seg_pat = 7'h10;
            default: seg_pat = 7'h7F;
        endcase
        if ((digit != '0) && (upper == '0)) begin
            seg_pat = 7'h7F;
        end
    end

    // Digit scan: seg and an are registered together from the same digit index.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            digit <= '0;
            seg   <= 7'h7F;
            an    <= '1;
        end else begin
            seg <= seg_pat;
            an  <= an_pat;
            if (presc == PW'(SCAN_DIV)) begin
                presc <= '0;
                digit <= (digit == DW'(NDIG - 1)) ? '0 : digit + DW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // High score is evaluated only on the game_over rising edge.
    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            go_d     <= 1'b0;
            hi_score <= '0;
        end else begin
            go_d <= game_over;
            if (game_over && !go_d && (score > hi_score)) begin
                hi_score <= score;
            end
        end
    end

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed scoreboard bench for score_display
module tb_score_display;

    localparam int SCORE_W = 14;
    localparam int NDIG    = 4;

    logic               clk3 = 1'b0;
    logic               reset;
    logic [SCORE_W-1:0] score;
    logic               game_over;
    logic [6:0]         seg;
    logic [NDIG-1:0]    an;
    logic [SCORE_W-1:0] hi_score;
    logic               busy;

    int checks = 0;
    int errors = 0;
    logic [27:0] sb[$];

    score_display #(.SCORE_W(SCORE_W), .NDIG(NDIG), .SCAN_DIV(0)) dut (
        .clk3(clk3), .reset(reset), .score(score), .game_over(game_over),
        .seg(seg), .an(an), .hi_score(hi_score), .busy(busy)
    );

    always #5 clk3 = ~clk3;

    task automatic tick();
        @(posedge clk3);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] exp_segs(input int v);
        logic [27:0] r;
        int sat;
        int p;
        sat = (v > 9999) ? 9999 : v;
        p = 1;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (i > 0 && (sat / p) == 0) r[i*7 +: 7] = 7'h7F;
            else                         r[i*7 +: 7] = seg_code((sat / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic drive(input int v, input bit push);
        score = SCORE_W'(v);
        if (push) sb.push_back(exp_segs(v));
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic scan_check(input string tag);
        logic [6:0]  got [NDIG];
        logic [27:0] exp;
        int idx;
        for (int i = 0; i < NDIG; i++) got[i] = 7'hxx;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        for (int i = 0; i < NDIG; i++) begin
            tick();
            case (an)
                4'hE: idx = 0;
                4'hD: idx = 1;
                4'hB: idx = 2;
                4'h7: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) check({tag, "_an_onehot"}, 32'(an), 32'hE);
            else got[idx] = seg;
        end
        for (int i = 0; i < NDIG; i++)
            check($sformatf("%s_dig%0d", tag, i), 32'(got[i]), 32'(exp[i*7 +: 7]));
    endtask

    initial begin
        int n;
        int elapsed;
        reset = 1'b0;
        score = '0;
        game_over = 1'b0;
        #23;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        check("rel_an", 32'(an), 32'hE);
        check("rel_seg", 32'(seg), 32'h40);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_hi", 32'(hi_score), 32'd0);

        // Normal conversion
        drive(1234, 1'b1);
        tick();
        wait_idle("conv1234", n);
        check("conv1234_busy_cycles", 32'(n), 32'd15);
        scan_check("conv1234");

        // Leading-zero blanking
        drive(7, 1'b1);
        tick();
        wait_idle("conv7", n);
        check("conv7_busy_cycles", 32'(n), 32'd15);
        scan_check("conv7");

        // Saturation and no retrigger while held
        drive(12000, 1'b1);
        tick();
        wait_idle("sat", n);
        scan_check("sat");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) n++;
        end
        check("sat_no_retrigger", 32'(n), 32'd0);

        // Change mid-conversion
        drive(100, 1'b1);
        elapsed = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            elapsed++;
        end
        drive(101, 1'b1);
        wait_idle("mid_a", n);
        elapsed += n;
        scan_check("mid_first");
        elapsed += NDIG;
        wait_idle("mid_b", n);
        elapsed += n;
        check("mid_elapsed_le_32", 32'(elapsed <= 2 * (SCORE_W + 2)), 32'd1);
        scan_check("mid_second");

        // High score
        drive(30, 1'b0);
        game_over = 1'b1;
        tick(); tick();
        check("hi_30", 32'(hi_score), 32'd30);
        game_over = 1'b0;
        tick();
        drive(50, 1'b0);
        game_over = 1'b1;
        tick(); tick();
        check("hi_50", 32'(hi_score), 32'd50);
        drive(60, 1'b0);
        tick(); tick();
        check("hi_held_level", 32'(hi_score), 32'd50);
        game_over = 1'b0;
        tick();
        drive(20, 1'b0);
        game_over = 1'b1;
        tick(); tick();
        check("hi_lower", 32'(hi_score), 32'd50);
        game_over = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        wait_idle("hi_settle", n);

        // Reset during SHIFT
        drive(999, 1'b0);
        tick(); tick();
        check("shift_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", 32'(hi_score), 32'd0);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_an", 32'(an), 32'hF);
        reset = 1'b1;
        sb.push_back(exp_segs(999));
        tick();
        check("midrst_rel_seg0", 32'(seg), 32'h40);
        tick();
        check("midrst_rel_an1", 32'(an), 32'hD);
        check("midrst_rel_seg1_blank", 32'(seg), 32'h7F);
        wait_idle("conv999", n);
        scan_check("conv999");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
